uart_rx_frame_ctrl: RTL and testbench

Frame controller for the UART receiver. It sits beside the edge/bit counter: it drives the counter's enable and consumes the counter's `bit_cnt`/`edge_cnt`. It oversamples `RX_IN` with a majority-of-3 vote, deserializes LSB-first data, and checks parity and stop bits. It delivers `P_DATA` with a one-cycle `data_valid` strobe to the downstream consumer.

---
 rtl/uart_rx_frame_ctrl.sv | 89 ++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: UART receive frame FSM with majority-vote sampling, parity/stop checks and strobed output word
//   CLK, RST (sync, active high); RX_IN serial line; Prescale 8/16/32; PAR_EN, PAR_TYP
//   bit_cnt/edge_cnt from the edge/bit counter, cnt_enable back to it
//   P_DATA + data_valid strobe; par_err, stp_err, strt_glitch strobes
//   UART_RX_ERR_CNT_EN adds err_cnt[7:0], a saturating count of error-strobe cycles
module uart_rx_frame_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [7:0]            bit_cnt,
  input  logic [5:0]            edge_cnt,
  output logic                  cnt_enable,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  strt_glitch
`ifdef UART_RX_ERR_CNT_EN
  ,
  output logic [7:0]            err_cnt
`endif
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state;
  logic [DATA_WIDTH-1:0] shreg;
  logic s0, s1, s2, frame_bad;
  logic [5:0] h;
  logic smp, bit_end, smp_done;
  assign h          = {1'b0, Prescale[5:1]};
  assign smp        = (s0 & s1) | (s0 & s2) | (s1 & s2);
  assign bit_end    = edge_cnt == Prescale - 6'd1;
  assign smp_done   = edge_cnt == h + 6'd2;
  assign cnt_enable = state != IDLE;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      shreg       <= '0;
      P_DATA      <= '0;
      {s0, s1, s2, frame_bad} <= '0;
      {data_valid, par_err, stp_err, strt_glitch} <= '0;
    end else begin
      {data_valid, par_err, stp_err, strt_glitch} <= '0;
      if (edge_cnt == h - 6'd1) s0 <= RX_IN;
      if (edge_cnt == h) s1 <= RX_IN;
      if (edge_cnt == h + 6'd1) s2 <= RX_IN;
      case (state)
        IDLE: if (!RX_IN) begin
          state     <= START;
          frame_bad <= 1'b0;
        end
        START: if (bit_end) begin
          state       <= smp ? IDLE : DATA;
          strt_glitch <= smp;
        end
        DATA: if (bit_end) begin
          shreg <= {smp, shreg[DATA_WIDTH-1:1]};
          if (bit_cnt == 8'(DATA_WIDTH)) state <= PAR_EN ? PARITY : STOP;
        end
        PARITY: if (bit_end) begin
          if (smp != (^shreg ^ PAR_TYP)) begin
            par_err   <= 1'b1;
            frame_bad <= 1'b1;
          end
          state <= STOP;
        end
        STOP: if (smp_done) begin
          stp_err <= !smp;
          if (smp && !frame_bad) begin
            P_DATA     <= shreg;
            data_valid <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef UART_RX_ERR_CNT_EN
  always_ff @(posedge CLK) begin
    if (RST) err_cnt <= '0;
    else if ((par_err | stp_err | strt_glitch) && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
`endif
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: directed frames against uart_rx_frame_ctrl with a behavioural edge/bit counter
module tb_uart_rx_frame_ctrl;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX_IN = 1'b1;
  logic [5:0] pre = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [7:0] bit_cnt = '0;
  logic [5:0] edge_cnt = '0;
  logic       cnt_enable;
  logic [7:0] P_DATA;
  logic       data_valid, par_err, stp_err, strt_glitch;
`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif
  int n_vec = 0, n_miss = 0;
  int dv_n = 0, pe_n = 0, se_n = 0, sg_n = 0;
  int b_dv, b_pe, b_se, b_sg;
  logic [7:0] dv_last = '0, dv_prev = '0;
  logic sg_d = 1'b0, cen_after_sg = 1'b1;

  uart_rx_frame_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(pre), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .bit_cnt(bit_cnt), .edge_cnt(edge_cnt), .cnt_enable(cnt_enable), .P_DATA(P_DATA),
    .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err), .strt_glitch(strt_glitch)
`ifdef UART_RX_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (!cnt_enable) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (edge_cnt == pre - 6'd1) begin
      edge_cnt <= '0;
      bit_cnt  <= bit_cnt + 8'd1;
    end else edge_cnt <= edge_cnt + 6'd1;
  end

  always @(negedge CLK) begin
    if (data_valid) begin
      dv_n    <= dv_n + 1;
      dv_prev <= dv_last;
      dv_last <= P_DATA;
    end
    if (par_err) pe_n <= pe_n + 1;
    if (stp_err) se_n <= se_n + 1;
    if (strt_glitch) sg_n <= sg_n + 1;
    sg_d <= strt_glitch;
    if (sg_d) cen_after_sg <= cnt_enable;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic snap();
    b_dv = dv_n; b_pe = pe_n; b_se = se_n; b_sg = sg_n;
  endtask

  task automatic drive_bit(input logic b);
    RX_IN = b;
    repeat (int'(pre)) @(negedge CLK);
  endtask

  task automatic send(input logic [7:0] d, input logic par_on, input logic par_bit, input logic stp, input int idle);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (par_on) drive_bit(par_bit);
    drive_bit(stp);
    RX_IN = 1'b1;
    repeat (idle) @(negedge CLK);
  endtask

  task automatic glitch();
    RX_IN = 1'b0;
    repeat (2) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (2 * int'(pre)) @(negedge CLK);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    chk("rst_dv", 32'(data_valid), 0);
    chk("rst_pdata", 32'(P_DATA), 0);
    chk("rst_cen", 32'(cnt_enable), 0);
    chk("rst_errs", 32'({par_err, stp_err, strt_glitch}), 0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    snap();
    send(8'hA5, 1'b0, 1'b0, 1'b1, 8);
    chk("f1_dv", 32'(dv_n - b_dv), 1);
    chk("f1_pdata", 32'(dv_last), 32'hA5);
    chk("f1_errs", 32'(pe_n - b_pe + se_n - b_se + sg_n - b_sg), 0);
    chk("f1_cen", 32'(cnt_enable), 0);

    pre = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    snap();
    send(8'h3C, 1'b1, 1'b0, 1'b1, 16);
    chk("par_ok_dv", 32'(dv_n - b_dv), 1);
    chk("par_ok_pdata", 32'(P_DATA), 32'h3C);
    chk("par_ok_pe", 32'(pe_n - b_pe), 0);
    snap();
    send(8'h3C, 1'b1, 1'b1, 1'b1, 16);
    chk("par_bad_pe", 32'(pe_n - b_pe), 1);
    chk("par_bad_dv", 32'(dv_n - b_dv), 0);
    chk("par_bad_hold", 32'(P_DATA), 32'h3C);

    pre = 6'd8; PAR_EN = 1'b0;
    snap();
    send(8'h55, 1'b0, 1'b0, 1'b0, 32);
    chk("stp_se", 32'(se_n - b_se), 1);
    chk("stp_dv", 32'(dv_n - b_dv), 0);
    chk("stp_idle", 32'(cnt_enable), 0);
    chk("stp_hold", 32'(P_DATA), 32'h3C);
    snap();
    send(8'h0F, 1'b0, 1'b0, 1'b1, 8);
    chk("after_stp_dv", 32'(dv_n - b_dv), 1);
    chk("after_stp_pdata", 32'(P_DATA), 32'h0F);

    snap();
    glitch();
    chk("gl_sg", 32'(sg_n - b_sg), 1);
    chk("gl_dv", 32'(dv_n - b_dv), 0);
    chk("gl_cen_next", 32'(cen_after_sg), 0);

    pre = 6'd32;
    snap();
    send(8'h00, 1'b0, 1'b0, 1'b1, 0);
    send(8'hFF, 1'b0, 1'b0, 1'b1, 32);
    chk("b2b_dv", 32'(dv_n - b_dv), 2);
    chk("b2b_first", 32'(dv_prev), 32'h00);
    chk("b2b_second", 32'(dv_last), 32'hFF);
    chk("b2b_errs", 32'(pe_n - b_pe + se_n - b_se + sg_n - b_sg), 0);

    pre = 6'd16;
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    RX_IN = 1'b1;
    repeat (8) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("mrst_cen", 32'(cnt_enable), 0);
    chk("mrst_pdata", 32'(P_DATA), 0);
    chk("mrst_strobes", 32'({data_valid, par_err, stp_err, strt_glitch}), 0);
`ifdef UART_RX_ERR_CNT_EN
    chk("mrst_errcnt", 32'(err_cnt), 0);
`endif
    repeat (48) @(negedge CLK);
    snap();
    send(8'h81, 1'b0, 1'b0, 1'b1, 16);
    chk("post_rst_dv", 32'(dv_n - b_dv), 1);
    chk("post_rst_pdata", 32'(P_DATA), 32'h81);

`ifdef UART_RX_ERR_CNT_EN
    for (int i = 0; i < 3; i++) glitch();
    chk("errcnt_3", 32'(err_cnt), 3);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("errcnt_rst", 32'(err_cnt), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
